// File: rtl/fir_tap_window_mc_if.sv
// Sample-in / tap-window-out handshake bundle for fir_tap_window_mc.
// The master modport is the producer/consumer side; the slave modport is the block itself.
interface fir_tap_window_mc_if #(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned N_TAPS   = 16,
    parameter int unsigned CH_W     = 2
);
    logic                         s_valid;
    logic                         s_ready;
    logic [IN_WIDTH-1:0]          s_data;
    logic [CH_W-1:0]              s_ch;
    logic                         m_valid;
    logic                         m_ready;
    logic [N_TAPS*IN_WIDTH-1:0]   m_taps;
    logic [CH_W-1:0]              m_ch;

    modport master (
        output s_valid, s_data, s_ch, m_ready,
        input  s_ready, m_valid, m_taps, m_ch
    );

    modport slave (
        input  s_valid, s_data, s_ch, m_ready,
        output s_ready, m_valid, m_taps, m_ch
    );
endinterface

// File: rtl/fir_tap_window_mc.sv
// Multi-channel FIR tap window: per-channel sample history, emits the full
// newest-first window of the channel just written through a single output register.
module fir_tap_window_mc #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned N_TAPS      = 16,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned PRIME_ZEROS = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    fir_tap_window_mc_if.slave    bus,
    output logic                  err_ch
);
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TW     = N_TAPS * IN_WIDTH;
    localparam int unsigned FILL_W = $clog2(N_TAPS + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N_TAPS);

    logic [TW-1:0]     hist_q [N_CH];
    logic [TW-1:0]     hist_d [N_CH];
    logic [FILL_W-1:0] fill_q [N_CH];
    logic [FILL_W-1:0] fill_d [N_CH];

    logic              m_valid_q, m_valid_d;
    logic [TW-1:0]     m_taps_q,  m_taps_d;
    logic [CH_W-1:0]   m_ch_q,    m_ch_d;
    logic              err_q,     err_d;

    logic              s_ready_c;
    logic              acc_c;
    logic              ch_ok_c;
    logic [TW-1:0]     shifted;
    logic [FILL_W-1:0] fill_nxt;

    // Single output register, no skid: accept only when the register is free or draining.
    assign s_ready_c = rst_n & ~flush & (~m_valid_q | bus.m_ready);
    assign acc_c     = bus.s_valid & s_ready_c;
    assign ch_ok_c   = ({1'b0, bus.s_ch} < (CH_W + 1)'(N_CH));

    // Next-state: history shift, fill tracking, window emission and drain.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        m_valid_d = m_valid_q & ~bus.m_ready;
        m_taps_d  = m_taps_q;
        m_ch_d    = m_ch_q;
        err_d     = 1'b0;
        shifted   = '0;
        fill_nxt  = '0;

        if (flush) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                hist_d[c] = '0;
                fill_d[c] = '0;
            end
            m_valid_d = 1'b0;
        end else if (acc_c && !ch_ok_c) begin
            err_d = 1'b1;
        end else if (acc_c) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (CH_W'(c) == bus.s_ch) begin
                    shifted   = {bus.s_data, hist_q[c][TW-1:IN_WIDTH]};
                    fill_nxt  = (fill_q[c] == FILL_FULL) ? FILL_FULL
                                                         : fill_q[c] + FILL_W'(1);
                    hist_d[c] = shifted;
                    fill_d[c] = fill_nxt;
                    if ((PRIME_ZEROS != 0) || (fill_nxt == FILL_FULL)) begin
                        m_taps_d  = shifted;
                        m_ch_d    = bus.s_ch;
                        m_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                hist_q[c] <= '0;
                fill_q[c] <= '0;
            end
            m_valid_q <= 1'b0;
            m_taps_q  <= '0;
            m_ch_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                hist_q[c] <= hist_d[c];
                fill_q[c] <= fill_d[c];
            end
            m_valid_q <= m_valid_d;
            m_taps_q  <= m_taps_d;
            m_ch_q    <= m_ch_d;
            err_q     <= err_d;
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_taps  = m_taps_q;
    assign bus.m_ch    = m_ch_q;
    assign err_ch      = err_q;

endmodule

// File: tb/tb_fir_tap_window_mc.sv
// Directed bench for fir_tap_window_mc: table-driven fill/interleave/refill vectors
// plus hand-written backpressure, flush, bad-channel, zero-prime and async-reset sequences.
module tb_fir_tap_window_mc;
    localparam int unsigned W  = 16;
    localparam int unsigned NT = 16;
    localparam int unsigned TW = NT * W;

    logic clk;
    logic rst_n;
    logic flush_a;
    logic flush_b;
    logic flush_c;
    logic err_a;
    logic err_b;
    logic err_c;

    fir_tap_window_mc_if #(.IN_WIDTH(W), .N_TAPS(NT), .CH_W(2)) bus_a ();
    fir_tap_window_mc_if #(.IN_WIDTH(W), .N_TAPS(NT), .CH_W(2)) bus_b ();
    fir_tap_window_mc_if #(.IN_WIDTH(W), .N_TAPS(NT), .CH_W(2)) bus_c ();

    fir_tap_window_mc #(.IN_WIDTH(W), .N_TAPS(NT), .N_CH(4), .PRIME_ZEROS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a), .err_ch(err_a));
    fir_tap_window_mc #(.IN_WIDTH(W), .N_TAPS(NT), .N_CH(3), .PRIME_ZEROS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b), .err_ch(err_b));
    fir_tap_window_mc #(.IN_WIDTH(W), .N_TAPS(NT), .N_CH(4), .PRIME_ZEROS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush_c), .bus(bus_c), .err_ch(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] data;
        logic         exp_valid;
        logic [1:0]   exp_ch;
        logic [W-1:0] exp_newest;
    } vec_t;

    vec_t vecs[$];
    logic [17:0] xfer_log[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Record every completed output transfer of dut_a as {ch, tap0}.
    always @(posedge clk) begin
        if (bus_a.m_valid && bus_a.m_ready)
            xfer_log.push_back({bus_a.m_ch, bus_a.m_taps[TW-1 -: W]});
    end

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window of consecutive samples, newest first: tap i = newest - i.
    function automatic logic [TW-1:0] ramp(input logic [W-1:0] newest);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NT); i++)
            r[(int'(NT) - i) * int'(W) - 1 -: W] = newest - W'(i);
        return r;
    endfunction

    function automatic vec_t mk(input int ch, input int data, input bit v, input int newest);
        vec_t t;
        t.ch         = 2'(ch);
        t.data       = W'(data);
        t.exp_valid  = v;
        t.exp_ch     = 2'(ch);
        t.exp_newest = W'(newest);
        return t;
    endfunction

    // Apply vectors back-to-back on dut_a with the consumer always ready.
    task automatic run_range(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            bus_a.s_valid = 1'b1;
            bus_a.s_ch    = vecs[k].ch;
            bus_a.s_data  = vecs[k].data;
            #1;
            check($sformatf("vec%0d_s_ready", k), TW'(bus_a.s_ready), TW'(1'b1));
            @(negedge clk);
            check($sformatf("vec%0d_m_valid", k), TW'(bus_a.m_valid), TW'(vecs[k].exp_valid));
            if (vecs[k].exp_valid) begin
                check($sformatf("vec%0d_m_ch", k), TW'(bus_a.m_ch), TW'(vecs[k].exp_ch));
                check($sformatf("vec%0d_m_taps", k), bus_a.m_taps, ramp(vecs[k].exp_newest));
            end
        end
        bus_a.s_valid = 1'b0;
    endtask

    task automatic flush_a_pulse();
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
    endtask

    initial begin
        // T1: ch0 1..16 (indices 0..15)
        for (int k = 1; k <= 16; k++) vecs.push_back(mk(0, k, k == 16, 16));
        // T2: interleave ch0 k / ch1 100+k, then ch0 17 (indices 16..48)
        for (int k = 1; k <= 16; k++) begin
            vecs.push_back(mk(0, k, k == 16, 16));
            vecs.push_back(mk(1, 100 + k, k == 16, 116));
        end
        vecs.push_back(mk(0, 17, 1, 17));
        // T4 refill after flush: ch0 201..216 (indices 49..64)
        for (int k = 1; k <= 16; k++) vecs.push_back(mk(0, 200 + k, k == 16, 216));

        rst_n   = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        bus_a.s_valid = 1'b0; bus_a.s_ch = '0; bus_a.s_data = '0; bus_a.m_ready = 1'b1;
        bus_b.s_valid = 1'b0; bus_b.s_ch = '0; bus_b.s_data = '0; bus_b.m_ready = 1'b1;
        bus_c.s_valid = 1'b0; bus_c.s_ch = '0; bus_c.s_data = '0; bus_c.m_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_m_valid", TW'(bus_a.m_valid), '0);
        check("rst_m_taps",  bus_a.m_taps, '0);
        check("rst_m_ch",    TW'(bus_a.m_ch), '0);
        check("rst_err_ch",  TW'(err_a), '0);
        check("rst_s_ready", TW'(bus_a.s_ready), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 fill and T2 interleave from clean histories
        run_range(0, 16);
        @(negedge clk);
        flush_a_pulse();
        run_range(16, 49);
        @(negedge clk);
        check("t2_drained", TW'(bus_a.m_valid), '0);

        // T3 backpressure: window for ch0=18 held while ch1=117 waits
        bus_a.m_ready = 1'b0;
        xfer_log.delete();
        bus_a.s_valid = 1'b1; bus_a.s_ch = 2'd0; bus_a.s_data = 16'd18;
        @(negedge clk);
        check("t3_m_valid", TW'(bus_a.m_valid), TW'(1'b1));
        bus_a.s_ch = 2'd1; bus_a.s_data = 16'd117;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("t3_hold%0d_s_ready", i), TW'(bus_a.s_ready), '0);
            check($sformatf("t3_hold%0d_m_ch", i), TW'(bus_a.m_ch), '0);
            check($sformatf("t3_hold%0d_m_taps", i), bus_a.m_taps, ramp(16'd18));
            @(negedge clk);
        end
        bus_a.m_ready = 1'b1;
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        check("t3_reload_valid", TW'(bus_a.m_valid), TW'(1'b1));
        check("t3_reload_ch", TW'(bus_a.m_ch), TW'(2'd1));
        check("t3_reload_taps", bus_a.m_taps, ramp(16'd117));
        @(negedge clk);
        check("t3_cleared", TW'(bus_a.m_valid), '0);
        check("t3_xfer_count", TW'(xfer_log.size()), TW'(2));
        if (xfer_log.size() == 2) begin
            check("t3_xfer0", TW'(xfer_log[0]), TW'({2'd0, 16'd18}));
            check("t3_xfer1", TW'(xfer_log[1]), TW'({2'd1, 16'd117}));
        end

        // T4 flush drops a pending window and all history
        bus_a.m_ready = 1'b0;
        bus_a.s_valid = 1'b1; bus_a.s_ch = 2'd0; bus_a.s_data = 16'd19;
        @(negedge clk);
        check("t4_pending", TW'(bus_a.m_valid), TW'(1'b1));
        bus_a.s_data = 16'h1234;
        flush_a = 1'b1;
        #1;
        check("t4_flush_s_ready", TW'(bus_a.s_ready), '0);
        @(negedge clk);
        flush_a = 1'b0;
        bus_a.s_valid = 1'b0;
        check("t4_dropped", TW'(bus_a.m_valid), '0);
        bus_a.m_ready = 1'b1;
        run_range(49, 65);

        // T5 bad channel on a 3-channel instance
        bus_b.s_valid = 1'b1; bus_b.s_ch = 2'd3; bus_b.s_data = 16'h7FFF;
        #1;
        check("t5_s_ready", TW'(bus_b.s_ready), TW'(1'b1));
        @(negedge clk);
        bus_b.s_valid = 1'b0;
        check("t5_err_pulse", TW'(err_b), TW'(1'b1));
        check("t5_no_valid", TW'(bus_b.m_valid), '0);
        @(negedge clk);
        check("t5_err_clear", TW'(err_b), '0);
        for (int k = 1; k <= 16; k++) begin
            bus_b.s_valid = 1'b1; bus_b.s_ch = 2'd2; bus_b.s_data = W'(k);
            @(negedge clk);
            if (k == 15) check("t5_not_yet", TW'(bus_b.m_valid), '0);
        end
        bus_b.s_valid = 1'b0;
        check("t5_win_valid", TW'(bus_b.m_valid), TW'(1'b1));
        check("t5_win_ch", TW'(bus_b.m_ch), TW'(2'd2));
        check("t5_win_taps", bus_b.m_taps, ramp(16'd16));

        // T6 zero-primed window, then asynchronous reset mid-stream
        bus_c.s_valid = 1'b1; bus_c.s_ch = 2'd2; bus_c.s_data = 16'hFFFB;
        @(negedge clk);
        bus_c.s_valid = 1'b0;
        check("t6_valid", TW'(bus_c.m_valid), TW'(1'b1));
        check("t6_ch", TW'(bus_c.m_ch), TW'(2'd2));
        check("t6_taps", bus_c.m_taps, {16'hFFFB, 240'h0});
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", TW'(bus_c.m_valid), '0);
        check("t6_async_taps", bus_c.m_taps, '0);
        check("t6_async_s_ready", TW'(bus_a.s_ready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
